// File: rtl/arm_pkg.sv
// Shared ARM datapath definitions: condition codes and {N,Z,C,V} flag positions.
package arm_pkg;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_unit_if.sv
// Decoder/ALU-facing signal bundle of the conditional-execution unit.
interface cond_unit_if;

   logic [3:0] Cond;
   logic [3:0] ALUFlags;
   logic [1:0] FlagW;
   logic       PCS;
   logic       RegW;
   logic       MemW;
   logic       NoWrite;
   logic       PCSrc;
   logic       RegWrite;
   logic       MemWrite;
   logic       CondEx;
   logic [3:0] Flags;

   modport master (
      output Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
      input  PCSrc, RegWrite, MemWrite, CondEx, Flags
   );

   modport slave (
      input  Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
      output PCSrc, RegWrite, MemWrite, CondEx, Flags
   );

endinterface

// File: rtl/cond_unit_check.sv
// Combinational ARM condition-field evaluator; kept standalone so a pipelined
// controller can reuse it on forwarded flags.
module cond_check
   import arm_pkg::*;
(
   input  logic [3:0] i_cond,
   input  logic [3:0] i_flags,
   output logic       o_cond_ex
);

   logic w_n, w_z, w_c, w_v;

   assign w_n = i_flags[FLAG_N];
   assign w_z = i_flags[FLAG_Z];
   assign w_c = i_flags[FLAG_C];
   assign w_v = i_flags[FLAG_V];

   always_comb begin
      o_cond_ex = 1'b1;
      case (i_cond)
         COND_EQ: o_cond_ex = w_z;
         COND_NE: o_cond_ex = ~w_z;
         COND_CS: o_cond_ex = w_c;
         COND_CC: o_cond_ex = ~w_c;
         COND_MI: o_cond_ex = w_n;
         COND_PL: o_cond_ex = ~w_n;
         COND_VS: o_cond_ex = w_v;
         COND_VC: o_cond_ex = ~w_v;
         COND_HI: o_cond_ex = w_c & ~w_z;
         COND_LS: o_cond_ex = ~w_c | w_z;
         COND_GE: o_cond_ex = (w_n == w_v);
         COND_LT: o_cond_ex = (w_n != w_v);
         COND_GT: o_cond_ex = ~w_z & (w_n == w_v);
         COND_LE: o_cond_ex = w_z | (w_n != w_v);
         COND_AL: o_cond_ex = 1'b1;
         // NV is treated as unconditional rather than trapping
         COND_NV: o_cond_ex = 1'b1;
         default: o_cond_ex = 1'b1;
      endcase
   end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution unit: holds {N,Z,C,V}, evaluates Cond on the stored
// flags and gates the decoder's PC/register/memory write requests.
module cond_unit
   import arm_pkg::*;
#(
   parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
   input  logic        clk,
   input  logic        reset,
   cond_unit_if.slave  bus
);

   logic [1:0] r_flags_nz;
   logic [1:0] r_flags_cv;
   logic [3:0] w_flags;
   logic       w_cond_ex;
   logic       w_we_nz;
   logic       w_we_cv;

   assign w_flags = {r_flags_nz, r_flags_cv};

   cond_check u_cond_check (
      .i_cond    (bus.Cond),
      .i_flags   (w_flags),
      .o_cond_ex (w_cond_ex)
   );

   // Write enables use the old flags, so a self-dependent instruction gates on pre-update state
   assign w_we_nz = bus.FlagW[1] & w_cond_ex;
   assign w_we_cv = bus.FlagW[0] & w_cond_ex;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_flags_nz <= FLAGS_RESET[FLAG_N:FLAG_Z];
      end else if (w_we_nz) begin
         r_flags_nz <= bus.ALUFlags[FLAG_N:FLAG_Z];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_flags_cv <= FLAGS_RESET[FLAG_C:FLAG_V];
      end else if (w_we_cv) begin
         r_flags_cv <= bus.ALUFlags[FLAG_C:FLAG_V];
      end
   end

   assign bus.CondEx   = w_cond_ex;
   assign bus.Flags    = w_flags;
   assign bus.PCSrc    = ~reset & bus.PCS  & w_cond_ex;
   assign bus.RegWrite = ~reset & bus.RegW & w_cond_ex & ~bus.NoWrite;
   assign bus.MemWrite = ~reset & bus.MemW & w_cond_ex;

endmodule

// File: tb/tb_cond_unit.sv
// Bench for cond_unit: behavioural flag/condition model checked every cycle,
// directed scenarios with literal expectations, then random instruction streams.
module tb_cond_unit;

   localparam logic [3:0] FLAGS_RESET = 4'b0000;

   logic clk;
   logic reset;
   int   n_pass;
   int   n_total;

   cond_unit_if u_if ();

   cond_unit #(.FLAGS_RESET(FLAGS_RESET)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ARM condition semantics: codes come in pairs, odd member is the inverse.
   function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v, base;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cy;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cy && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      if (c[3:1] == 3'd7) return 1'b1;
      return c[0] ? !base : base;
   endfunction

   logic [3:0] m_flags;
   logic       m_valid;

   initial m_valid = 1'b0;

   always @(posedge clk) begin
      logic ok;
      logic [3:0] nxt;
      if (reset) begin
         m_flags <= FLAGS_RESET;
         m_valid <= 1'b1;
      end else if (m_valid) begin
         ok  = model_cond(u_if.Cond, m_flags);
         nxt = m_flags;
         if (ok && u_if.FlagW[1]) nxt[3:2] = u_if.ALUFlags[3:2];
         if (ok && u_if.FlagW[0]) nxt[1:0] = u_if.ALUFlags[1:0];
         m_flags <= nxt;
      end
   end

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      logic ce;
      if (m_valid) begin
         ce = model_cond(u_if.Cond, m_flags);
         chk("flags",    u_if.Flags, m_flags);
         chk("condex",   {3'b0, u_if.CondEx}, {3'b0, ce});
         chk("pcsrc",    {3'b0, u_if.PCSrc},    {3'b0, !reset && u_if.PCS && ce});
         chk("regwrite", {3'b0, u_if.RegWrite}, {3'b0, !reset && u_if.RegW && ce && !u_if.NoWrite});
         chk("memwrite", {3'b0, u_if.MemWrite}, {3'b0, !reset && u_if.MemW && ce});
      end
   end

   // Apply one instruction just after a rising edge, return at the following falling edge.
   task automatic drive(input logic rst, input logic [3:0] c, input logic [3:0] alu,
                        input logic [1:0] fw, input logic pcs, input logic regw,
                        input logic memw, input logic nw);
      @(posedge clk);
      #1;
      reset         = rst;
      u_if.Cond     = c;
      u_if.ALUFlags = alu;
      u_if.FlagW    = fw;
      u_if.PCS      = pcs;
      u_if.RegW     = regw;
      u_if.MemW     = memw;
      u_if.NoWrite  = nw;
      @(negedge clk);
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      reset         = 1'b1;
      u_if.Cond     = 4'b1110;
      u_if.ALUFlags = 4'b1111;
      u_if.FlagW    = 2'b11;
      u_if.PCS      = 1'b1;
      u_if.RegW     = 1'b1;
      u_if.MemW     = 1'b1;
      u_if.NoWrite  = 1'b0;

      // reset holds outputs low and flags at reset value
      drive(1, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0);
      chk("rst_flags", u_if.Flags, 4'b0000);
      chk("rst_pcsrc", {3'b0, u_if.PCSrc}, 4'd0);
      chk("rst_regw",  {3'b0, u_if.RegWrite}, 4'd0);
      chk("rst_memw",  {3'b0, u_if.MemWrite}, 4'd0);
      drive(0, 4'b1110, 4'b0000, 2'b00, 1, 1, 1, 0);
      chk("al_outs", {1'b0, u_if.PCSrc, u_if.RegWrite, u_if.MemWrite}, 4'b0111);

      // compare then branch
      drive(0, 4'b1110, 4'b0100, 2'b11, 0, 1, 0, 1);
      chk("cmp_regw", {3'b0, u_if.RegWrite}, 4'd0);
      drive(0, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 0);
      chk("beq_flags", u_if.Flags, 4'b0100);
      chk("beq_pcsrc", {3'b0, u_if.PCSrc}, 4'd1);
      drive(0, 4'b0001, 4'b0000, 2'b00, 1, 0, 0, 0);
      chk("bne_pcsrc", {3'b0, u_if.PCSrc}, 4'd0);

      // partial writes
      drive(0, 4'b1110, 4'b1111, 2'b11, 0, 0, 0, 0);
      drive(0, 4'b1110, 4'b0000, 2'b10, 0, 0, 0, 0);
      chk("pw_start", u_if.Flags, 4'b1111);
      drive(0, 4'b1110, 4'b0000, 2'b01, 0, 0, 0, 0);
      chk("pw_nz", u_if.Flags, 4'b0011);
      drive(0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0);
      chk("pw_cv", u_if.Flags, 4'b0000);

      // failed condition blocks memory write and flag update
      drive(0, 4'b1110, 4'b0100, 2'b11, 0, 0, 0, 0);
      drive(0, 4'b0001, 4'b1011, 2'b11, 0, 0, 1, 0);
      chk("fc_memw",   {3'b0, u_if.MemWrite}, 4'd0);
      chk("fc_condex", {3'b0, u_if.CondEx}, 4'd0);
      drive(0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0);
      chk("fc_flags", u_if.Flags, 4'b0100);

      // exhaustive Cond x Flags sweep
      for (int f = 0; f < 16; f++) begin
         drive(0, 4'b1110, 4'(f), 2'b11, 0, 0, 0, 0);
         for (int c = 0; c < 16; c++) begin
            drive(0, 4'(c), 4'($urandom), 2'b00, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            if (f == 9 && c == 12) chk("gt_1001", {3'b0, u_if.CondEx}, 4'd1);
            if (f == 8 && c == 13) chk("le_1000", {3'b0, u_if.CondEx}, 4'd1);
            if (f == 4 && c == 8)  chk("hi_0100", {3'b0, u_if.CondEx}, 4'd0);
         end
      end

      // reset collides with a flag write
      drive(0, 4'b1110, 4'b1010, 2'b11, 0, 0, 0, 0);
      drive(1, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0);
      chk("rc_before", u_if.Flags, 4'b1010);
      drive(0, 4'b1111, 4'b0000, 2'b00, 0, 0, 0, 0);
      chk("rc_after", u_if.Flags, FLAGS_RESET);

      // random instruction stream
      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(0, 31) == 0), 4'($urandom), 4'($urandom), 2'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/cond_unit.md
# cond_unit

Conditional-execution unit for the single-cycle ARM datapath: the consumer of the ALU's `{N,Z,C,V}` flag bus. It holds the architectural status flags and updates them under the decoder's flag-write enables. Each cycle it evaluates the instruction's 4-bit condition field against the stored flags, and gates the decoder's PC, register-file and memory write requests. It sits between the main decoder and the datapath write ports.

## Interface

**Parameters**
- `FLAGS_RESET`, default `4'b0000`: value loaded into the flag register on reset, ordered `{N,Z,C,V}`.

**Ports**
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `Cond`  in  4  instruction condition field, bits [31:28].
- `ALUFlags`  in  4  `{N,Z,C,V}` from the ALU for the current instruction.
- `FlagW`  in  2  flag-write request. Bit 1 requests an N,Z update; bit 0 requests a C,V update.
- `PCS`  in  1  decoder request to write the PC (branch or write to R15).
- `RegW`  in  1  decoder register-file write request.
- `MemW`  in  1  decoder memory write request.
- `NoWrite`  in  1  suppresses the register write for compare-class instructions (CMP/CMN/TST/TEQ).
- `PCSrc`  out  1  gated PC write.
- `RegWrite`  out  1  gated register write.
- `MemWrite`  out  1  gated memory write.
- `CondEx`  out  1  condition-passed indication for the current instruction.
- `Flags`  out  4  current registered `{N,Z,C,V}`.

## Operation

**Condition evaluation**
- `CondEx` is evaluated on registered `Flags` only, never on `ALUFlags`.
- EQ 0000: Z
- NE 0001: ~Z
- CS 0010: C
- CC 0011: ~C
- MI 0100: N
- PL 0101: ~N
- VS 0110: V
- VC 0111: ~V
- HI 1000: C & ~Z
- LS 1001: ~C | Z
- GE 1010: N==V
- LT 1011: N!=V
- GT 1100: ~Z & (N==V)
- LE 1101: Z | (N!=V)
- AL 1110: 1
- 1111: 1 (unconditional; no trap).

**Gating**
- `PCSrc = PCS & CondEx`
- `RegWrite = RegW & CondEx & ~NoWrite`
- `MemWrite = MemW & CondEx`
- While `reset` is high, `PCSrc`, `RegWrite` and `MemWrite` are forced to 0 regardless of other inputs.

**Flag register**
- On a rising edge with `reset` = 0, the `{N,Z}` half (`Flags[3:2]`) loads `ALUFlags[3:2]` iff `FlagW[1] & CondEx`.
- On a rising edge with `reset` = 0, the `{C,V}` half (`Flags[1:0]`) loads `ALUFlags[1:0]` iff `FlagW[0] & CondEx`.
- Each half holds its value otherwise; the two halves are independent.
- A failed condition never updates any flag.

## Timing

- Reset values: `Flags` = `FLAGS_RESET`; `PCSrc`, `RegWrite`, `MemWrite` = 0. `CondEx` follows `Cond` evaluated against `FLAGS_RESET`.
- Evaluation latency is 0 cycles: `CondEx` and the three gated outputs are combinational from `Cond`, `Flags` and the request inputs.
- Flag update latency is 1 cycle: flags written by instruction *i* are first visible to instruction *i+1*.
- An instruction whose `Cond` depends on the flags it is itself writing sees the old flags, both for evaluation and for its own write gating.
- `reset` asserted in the same cycle as a flag write: reset wins and `Flags` = `FLAGS_RESET`.
- There is no other state, and no handshake.

## Structure

- Shared package `arm_pkg` holds:
  - condition code constants `COND_EQ` … `COND_AL`, `COND_NV`;
  - flag bit indices `FLAG_N`=3, `FLAG_Z`=2, `FLAG_C`=1, `FLAG_V`=0.
- The ALU uses the same flag indices.
- Sub-module `cond_check`: purely combinational, inputs `Cond` and `Flags`, output `CondEx`. It is instantiated once here and is reusable by a later pipelined controller.
- The flag register is two 2-bit enabled registers in `cond_unit`.

## Test plan

- **Reset:** hold `reset`=1 with `PCS`=`RegW`=`MemW`=1 and `FlagW`=11. Required: outputs 0 and `Flags`=0000. Release reset; with `Cond`=1110 all three outputs are 1.
- **Compare then branch:** cycle 0 drives `ALUFlags`=0100, `FlagW`=11, `Cond`=1110, `NoWrite`=1, `RegW`=1 (CMP), giving `RegWrite`=0. Cycle 1 drives `Cond`=0000, `PCS`=1, giving `Flags`=0100 and `PCSrc`=1. Repeat cycle 1 with `Cond`=0001; required `PCSrc`=0.
- **Partial write:** starting from `Flags`=1111, apply `FlagW`=10 with `ALUFlags`=0000 and `Cond`=1110. Required next `Flags`=0011. Then apply `FlagW`=01 with `ALUFlags`=0000; required `Flags`=0000.
- **Failed condition:** with `Flags`=0100, drive `Cond`=0001, `FlagW`=11, `ALUFlags`=1011, `MemW`=1. Required: `MemWrite`=0 and `Flags` unchanged at 0100.
- **Exhaustive conditions:** sweep all 16 `Cond` × 16 `Flags` combinations (flags loaded via `FlagW`=11, `Cond`=1110). Required: `CondEx` matches the table above, e.g. GT with `Flags`=1001 gives 1; LE with `Flags`=1000 gives 1.
- **Reset collision:** assert `reset` together with `FlagW`=11 and `ALUFlags`=1111. Required: `Flags`=`FLAGS_RESET` on the next cycle.
